btn_event_arbiter: RTL and testbench
====================================

// Module: btn_event_arbiter
// PURPOSE
//   Collects single-cycle press pulses from NUM_BTN btn_debounce instances and serialises
//   them into one ordered event stream with a valid/ready handshake.
//   Sits between the debouncers and the mode/control FSM, so no press is lost
//   when several buttons fire together or the consumer stalls.
//   Arbitration is round-robin over per-button pending flags, buffered by a small FIFO.
// PARAMETERS
//   NUM_BTN    4  number of button pulse inputs (2..8)
//   FIFO_DEPTH 4  event FIFO entries; power of two, >= 2
//   CODE_W     $clog2(NUM_BTN)  derived localparam; event code width
// PORTS
//   clk          in   1        system clock (100 MHz)
//   reset        in   1        synchronous, active-high reset
//   i_btn_pulse  in   NUM_BTN  1-clk press pulses, bit k = button k
//   o_evt_valid  out  1        head event available
//   o_evt_code   out  CODE_W   index of button for head event
//   i_evt_ready  in   1        consumer accepts head event this cycle
//   o_busy       out  1        any pending flag set or FIFO non-empty
//   o_overflow   out  1        sticky: at least one press was coalesced
//   o_drop_cnt   out  8        coalesced-press count (only with BTN_DROP_CNT_EN)
// BEHAVIOUR
//   Reset (clk edge with reset=1): pending=0, FIFO empty, rr_ptr=NUM_BTN-1, o_evt_valid=0,
//     o_evt_code=0, o_busy=0, o_overflow=0, o_drop_cnt=0. Reset wins over all other inputs
//     and aborts work in flight; queued and pending events are discarded.
//   Pending stage: pulse on bit k at edge sets pend[k]. If pend[k] is cleared by a grant
//     on the same edge as a new pulse on k, pend[k] stays 1 (new event, not a drop).
//   Coalesce: pulse on k while pend[k]=1 and k not granted this cycle -> event merged,
//     o_overflow<=1, drop counter +1 (saturates at 255).
//   Arbiter: grant when pend!=0 and FIFO not full (registered count < FIFO_DEPTH).
//     Search order rr_ptr+1, rr_ptr+2 ... mod NUM_BTN; first set bit g wins.
//     On grant: push g, clear pend[g], rr_ptr<=g. No grant -> rr_ptr unchanged.
//     At most one grant per cycle.
//   FIFO: first-word-fall-through. o_evt_valid = !empty; o_evt_code = head entry
//     (0 when empty). Pop on o_evt_valid & i_evt_ready.
//     Full with simultaneous pop: the pop happens, the push is blocked that cycle, and
//       the granted event retries next cycle (fullness is judged on registered count).
//     Not full: push and pop in the same cycle are both allowed; count is unchanged.
//     Pointers wrap modulo FIFO_DEPTH.
//   Latency: idle, pulse high in cycle 0 -> pend set in cycle 1 -> o_evt_valid=1 in cycle 2.
//   Throughput: 1 event/cycle sustained with ready held 1.
//   Ordering: events from one button leave in press order. Cross-button order follows grant order.
//   o_busy = |pend | !empty, registered-equivalent, no combinational path from i_btn_pulse.
//   Control FSM (2 states) tracks the sticky flag: CLEAN -> DIRTY on the first coalesce;
//     DIRTY holds until reset. o_overflow = (state==DIRTY).
// CONFIGURATION
//   BTN_DROP_CNT_EN defined: 8-bit saturating o_drop_cnt port and its counter are present.
//   Not defined: port and counter are absent; o_overflow is still provided.
// STRUCTURE
//   Shared package btn_pkg: NUM_BTN_DEF=4, EVT_FIFO_DEPTH_DEF=4, DROP_CNT_W=8,
//     button index localparams (BTN_RUN=0, BTN_CLEAR=1, BTN_MODE=2, BTN_SET=3).
//   One sub-module: btn_evt_fifo (FWFT, params WIDTH/DEPTH, push/pop/full/empty/count).
//   Pending flags, round-robin search and the overflow FSM stay in btn_event_arbiter.
// TESTING
//   1 Single press: pulse bit2 in cycle 0, ready=1 -> valid=1, code=2 in cycle 2 only;
//     busy=0 from cycle 3.
//   2 Simultaneous: pulse 4'b1011 after reset, ready=1 -> codes 0,1,3 in consecutive
//     cycles; rr_ptr ends at 3.
//   3 Back-pressure: ready=0, pulses btn0,1,2,3 then btn0,btn1 again -> FIFO holds 0,1,2,3
//     and pend=4'b0011; raise ready -> codes 0,1,2,3,0,1; overflow stays 0.
//   4 Coalesce: ready=0, FIFO full, pulse btn1 twice while pend[1]=1 -> overflow=1,
//     drop_cnt=1, only one extra btn1 event emitted.
//   5 Fairness: pulse bits 0 and 1 every cycle, ready=1 -> codes alternate 0,1,0,1;
//     no starvation over 100 cycles.
//   6 Reset mid-run: reset with 3 events queued and pend!=0 -> next cycle valid=0, busy=0,
//     overflow=0; post-reset pulse btn3 -> code 3 after 2 cycles.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared constants for the button front-end: default sizes, drop-counter
// width and symbolic button indices. Also provides the saturating add used
// by the coalesced-press counter.
package btn_pkg;

    localparam int NUM_BTN_DEF        = 4;
    localparam int EVT_FIFO_DEPTH_DEF = 4;
    localparam int DROP_CNT_W         = 8;

    localparam int BTN_RUN   = 0;
    localparam int BTN_CLEAR = 1;
    localparam int BTN_MODE  = 2;
    localparam int BTN_SET   = 3;

    // Saturating add; inc is a per-cycle merged-press count (at most 8).
    function automatic logic [DROP_CNT_W-1:0] drop_sat_add(
        input logic [DROP_CNT_W-1:0] cnt,
        input logic [3:0]            inc
    );
        logic [DROP_CNT_W:0] sum;
        sum = {1'b0, cnt} + (DROP_CNT_W+1)'(inc);
        return sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/btn_event_arbiter_if.sv
// Event stream handshake between the button arbiter (master) and its
// consumer (slave).
//   evt_valid : head event available       (master -> slave)
//   evt_code  : button index of head event (master -> slave)
//   evt_ready : consumer accepts head      (slave  -> master)
interface btn_event_arbiter_if #(
    parameter int NUM_BTN = 4
);
    localparam int CODE_W = $clog2(NUM_BTN);

    logic              evt_valid;
    logic [CODE_W-1:0] evt_code;
    logic              evt_ready;

    modport master (output evt_valid, output evt_code, input  evt_ready);
    modport slave  (input  evt_valid, input  evt_code, output evt_ready);

endinterface

// File: rtl/btn_evt_fifo.sv
// First-word-fall-through event FIFO.
//   clk, reset    : clock, synchronous active-high reset
//   i_push/i_push_data : write request; ignored when full
//   i_pop         : read request; ignored when empty
//   o_head        : head entry, 0 when empty
//   o_full/o_empty/o_count : status from the registered occupancy
// DEPTH must be a power of two so pointers wrap by natural overflow.
module btn_evt_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible between rd and wr.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/btn_event_arbiter.sv
// Serialises single-cycle press pulses from NUM_BTN debouncers into one
// ordered event stream. Each button has a pending flag; a round-robin
// search grants one flag per cycle into a FWFT FIFO, which feeds the
// valid/ready consumer interface.
//   clk, reset   : clock, synchronous active-high reset
//   i_btn_pulse  : 1-clk press pulses, bit k = button k
//   evt_if       : master side of the event handshake (valid/code/ready)
//   o_busy       : any pending flag set or FIFO non-empty
//   o_overflow   : sticky, a press was merged into an already-pending one
//   o_drop_cnt   : saturating merged-press count (BTN_DROP_CNT_EN only)
// Optional feature macro: BTN_DROP_CNT_EN adds o_drop_cnt and its counter.
module btn_event_arbiter
    import btn_pkg::*;
#(
    parameter int NUM_BTN    = NUM_BTN_DEF,
    parameter int FIFO_DEPTH = EVT_FIFO_DEPTH_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_BTN-1:0]      i_btn_pulse,
    btn_event_arbiter_if.master     evt_if,
    output logic                    o_busy,
`ifdef BTN_DROP_CNT_EN
    output logic                    o_overflow,
    output logic [DROP_CNT_W-1:0]   o_drop_cnt
`else
    output logic                    o_overflow
`endif
);
    localparam int CODE_W = $clog2(NUM_BTN);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [0:0] ST_CLEAN = 1'b0;
    localparam logic [0:0] ST_DIRTY = 1'b1;

    logic [NUM_BTN-1:0] r_pend;
    logic [CODE_W-1:0]  r_rr_ptr;
    logic [0:0]         r_state;

    logic               w_found;
    logic               w_grant;
    logic [CODE_W-1:0]  w_gnt_idx;
    logic [NUM_BTN-1:0] w_grant_vec;
    logic [NUM_BTN-1:0] w_coal;
    logic               w_full;
    logic               w_empty;
    logic [CNT_W-1:0]   w_count;
    logic [CODE_W-1:0]  w_head;
    logic               w_pop;

    // Round-robin: scan rr_ptr+1, rr_ptr+2, ... and take the first pending
    // flag. Fullness comes from the registered count, so a pop this cycle
    // does not open room for a push until the next cycle.
    always_comb begin
        int idx;
        w_found     = 1'b0;
        w_gnt_idx   = r_rr_ptr;
        w_grant_vec = '0;
        for (int i = 1; i <= NUM_BTN; i++) begin
            idx = (int'(r_rr_ptr) + i) % NUM_BTN;
            if (!w_found && r_pend[idx]) begin
                w_found   = 1'b1;
                w_gnt_idx = CODE_W'(idx);
            end
        end
        w_grant = w_found & ~w_full;
        if (w_grant) w_grant_vec[w_gnt_idx] = 1'b1;
    end

    // A pulse on a button whose flag is granted this cycle re-arms the flag
    // (a fresh event); otherwise a pulse on a set flag is merged.
    assign w_coal = i_btn_pulse & r_pend & ~w_grant_vec;
    assign w_pop  = evt_if.evt_valid & evt_if.evt_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend   <= '0;
            r_rr_ptr <= CODE_W'(NUM_BTN - 1);
            r_state  <= ST_CLEAN;
        end else begin
            r_pend <= (r_pend & ~w_grant_vec) | i_btn_pulse;
            if (w_grant) r_rr_ptr <= w_gnt_idx;
            if (r_state == ST_CLEAN && |w_coal) r_state <= ST_DIRTY;
        end
    end

`ifdef BTN_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (reset) r_drop_cnt <= '0;
        else if (|w_coal) r_drop_cnt <= drop_sat_add(r_drop_cnt, 4'($countones(w_coal)));
    end

    assign o_drop_cnt = r_drop_cnt;
`endif

    btn_evt_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_grant),
        .i_push_data (w_gnt_idx),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count)
    );

    assign evt_if.evt_valid = ~w_empty;
    assign evt_if.evt_code  = w_head;
    assign o_busy           = (|r_pend) | (w_count != '0);
    assign o_overflow       = (r_state == ST_DIRTY);

endmodule

// File: tb/tb_btn_event_arbiter.sv
module tb_btn_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] pulse;
    logic       busy;
    logic       overflow;
`ifdef BTN_DROP_CNT_EN
    logic [7:0] drop;
`endif

    int vecs = 0;
    int errs = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    btn_event_arbiter_if #(.NUM_BTN(4)) evt_if ();

    btn_event_arbiter #(.NUM_BTN(4), .FIFO_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_btn_pulse (pulse),
        .evt_if      (evt_if),
        .o_busy      (busy),
`ifdef BTN_DROP_CNT_EN
        .o_overflow  (overflow),
        .o_drop_cnt  (drop)
`else
        .o_overflow  (overflow)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pulse = '0;
        evt_if.evt_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Accept events with ready=1 and compare against exp_q in order; then
    // require the stream to go quiet.
    task automatic drain(input string tag);
        int k;
        k = 0;
        evt_if.evt_ready = 1'b1;
        for (int c = 0; c < 30 && k < exp_q.size(); c++) begin
            if (evt_if.evt_valid) begin
                chk(tag, 32'(evt_if.evt_code), 32'(exp_q[k]));
                k++;
            end
            tick();
        end
        if (k < exp_q.size()) chk({tag, "_timeout"}, 32'(k), 32'(exp_q.size()));
        tick();
        chk({tag, "_quiet"}, 32'(evt_if.evt_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset state
        do_reset();
        chk("rst_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("rst_code", 32'(evt_if.evt_code), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
`ifdef BTN_DROP_CNT_EN
        chk("rst_drop", 32'(drop), 32'd0);
`endif

        // 1: single press, two-cycle latency
        evt_if.evt_ready = 1'b1;
        pulse = 4'b0100; tick(); pulse = '0;
        chk("t1_c1_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("t1_c1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_c2_valid", 32'(evt_if.evt_valid), 32'd1);
        chk("t1_c2_code", 32'(evt_if.evt_code), 32'd2);
        tick();
        chk("t1_c3_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("t1_c3_busy", 32'(busy), 32'd0);

        // 2: simultaneous presses leave in round-robin order, back to back
        do_reset();
        evt_if.evt_ready = 1'b1;
        pulse = 4'b1011; tick(); pulse = '0;
        chk("t2_c1_valid", 32'(evt_if.evt_valid), 32'd0);
        tick(); chk("t2_c2_code", {31'(evt_if.evt_code), evt_if.evt_valid}, {31'd0, 1'b1});
        tick(); chk("t2_c3_code", {31'(evt_if.evt_code), evt_if.evt_valid}, {31'd1, 1'b1});
        tick(); chk("t2_c4_code", {31'(evt_if.evt_code), evt_if.evt_valid}, {31'd3, 1'b1});
        tick(); chk("t2_c5_busy", {31'(busy), evt_if.evt_valid}, 32'd0);

        // Pulse on a button granted the same edge re-arms it: two events, no merge
        pulse = 4'b0001; tick();
        pulse = 4'b0001; tick(); pulse = '0;
        chk("t2b_c2", {31'(evt_if.evt_code), evt_if.evt_valid}, {31'd0, 1'b1});
        tick();
        chk("t2b_c3", {31'(evt_if.evt_code), evt_if.evt_valid}, {31'd0, 1'b1});
        tick();
        chk("t2b_c4_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("t2b_ovf", 32'(overflow), 32'd0);

        // 3: back-pressure, FIFO fills and pending flags hold the rest
        do_reset();
        for (int b = 0; b < 4; b++) begin
            pulse = 4'(1 << b); tick();
        end
        pulse = 4'b0001; tick();
        pulse = 4'b0010; tick();
        pulse = '0;
        chk("t3_hold", {30'(evt_if.evt_code), evt_if.evt_valid, busy}, {30'd0, 1'b1, 1'b1});
        chk("t3_ovf0", 32'(overflow), 32'd0);
        exp_q = '{0, 1, 2, 3, 0, 1};
        drain("t3_drain");
        chk("t3_ovf_end", 32'(overflow), 32'd0);

        // 4: coalesce while FIFO is full
        do_reset();
        pulse = 4'b1111; tick(); pulse = '0;
        tick(); tick(); tick(); tick();
        pulse = 4'b0010; tick();
        chk("t4_ovf_before", 32'(overflow), 32'd0);
        pulse = 4'b0010; tick(); pulse = '0;
        chk("t4_ovf", 32'(overflow), 32'd1);
`ifdef BTN_DROP_CNT_EN
        chk("t4_drop", 32'(drop), 32'd1);
`endif
        exp_q = '{0, 1, 2, 3, 1};
        drain("t4_drain");
        chk("t4_ovf_sticky", 32'(overflow), 32'd1);

        // 5: fairness, two buttons hammered every cycle at full throughput
        do_reset();
        evt_if.evt_ready = 1'b1;
        pulse = 4'b0011; tick();
        chk("t5_c1_valid", 32'(evt_if.evt_valid), 32'd0);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("t5_alt", {31'(evt_if.evt_code), evt_if.evt_valid}, {31'(i % 2), 1'b1});
        end
        pulse = '0;
        for (int i = 0; i < 5; i++) tick();
        chk("t5_busy_end", 32'(busy), 32'd0);
        chk("t5_ovf", 32'(overflow), 32'd1);

        // 6: reset with events queued and flags pending
        evt_if.evt_ready = 1'b0;
        pulse = 4'b1111; tick(); pulse = '0;
        tick(); tick(); tick();
        chk("t6_pre", {30'd0, evt_if.evt_valid, busy}, {30'd0, 1'b1, 1'b1});
        reset = 1'b1; pulse = 4'b1111; tick();
        reset = 1'b0; pulse = '0;
        chk("t6_rst_valid", 32'(evt_if.evt_valid), 32'd0);
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_ovf", 32'(overflow), 32'd0);
`ifdef BTN_DROP_CNT_EN
        chk("t6_rst_drop", 32'(drop), 32'd0);
`endif
        evt_if.evt_ready = 1'b1;
        pulse = 4'b1000; tick(); pulse = '0;
        chk("t6_c1_valid", 32'(evt_if.evt_valid), 32'd0);
        tick();
        chk("t6_c2", {31'(evt_if.evt_code), evt_if.evt_valid}, {31'd3, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
